cochlea_readout_rx: RTL and testbench



---
 rtl/cochlea_readout_rx.sv | 146 ++++++++++++++
 tb/tb_cochlea_readout_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cochlea_readout_rx.sv
// cochlea_readout_rx: receive end of a channel core readout bus.
// Integrates 2-bit I/Q feedback codes over WINDOW strobes into signed
// counts, then queues each finished window as a frame in a small FIFO
// with a valid/ready drain port.
// Optional build macro: COCHLEA_RX_ILLEGAL_CNT_EN enables the saturating
// count of illegal (2'b11) codes on illegal_cnt; otherwise it reads 0.
module cochlea_readout_rx #(
    parameter int WINDOW = 64,
    parameter int ACC_W  = 8,
    parameter int DEPTH  = 4
) (
    input  logic               clk_master,
    input  logic               rstb,
    input  logic               run_en,
    input  logic               sample_en,
    input  logic [1:0]         read_out_I,
    input  logic [1:0]         read_out_Q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*ACC_W-1:0] out_data,
    output logic [3:0]         out_seq,
    output logic               ovf,
    input  logic               ovf_clr,
    output logic [7:0]         illegal_cnt
);

    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(WINDOW - 1);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);

    // +1 for fb1, -1 for fb2; idle and illegal codes add nothing
    function automatic logic signed [ACC_W-1:0] dec(input logic [1:0] code);
        case (code)
            2'b10:   dec = ACC_W'(1);
            2'b01:   dec = '1;
            default: dec = '0;
        endcase
    endfunction

    logic signed [ACC_W-1:0] acc_i, acc_q, sum_i, sum_q;
    logic [CNT_W-1:0]        smp_cnt;
    logic                    accept, close;

    assign accept = run_en & sample_en;
    assign close  = accept && (smp_cnt == LAST_SMP);
    assign sum_i  = acc_i + dec(read_out_I);
    assign sum_q  = acc_q + dec(read_out_Q);

    // Window integration; the closing strobe's contribution goes straight
    // into the pushed frame while the accumulators restart from zero.
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            acc_i   <= '0;
            acc_q   <= '0;
            smp_cnt <= '0;
        end else if (!run_en) begin
            acc_i   <= '0;
            acc_q   <= '0;
            smp_cnt <= '0;
        end else if (accept) begin
            if (close) begin
                acc_i   <= '0;
                acc_q   <= '0;
                smp_cnt <= '0;
            end else begin
                acc_i   <= sum_i;
                acc_q   <= sum_q;
                smp_cnt <= smp_cnt + 1'b1;
            end
        end
    end

    logic [2*ACC_W-1:0] mem_data [DEPTH];
    logic [3:0]         mem_seq  [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic [3:0]         frame_seq;
    logic               full, pop, push_ok, drop;

    assign full    = (count == FULL_CNT);
    assign pop     = out_valid & out_ready;
    assign push_ok = close & (~full | pop);
    assign drop    = close & full & ~pop;

    // Frame storage; a pop in the same cycle frees the slot for a full push
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_data[k] <= '0;
                mem_seq[k]  <= '0;
            end
        end else if (push_ok) begin
            mem_data[wr_ptr] <= {sum_i, sum_q};
            mem_seq[wr_ptr]  <= frame_seq;
        end
    end

    // Pointers, occupancy and the frame counter (which also counts drops)
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_seq <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (close) frame_seq <= frame_seq + 1'b1;
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb)        ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_seq   = out_valid ? mem_seq[rd_ptr]  : '0;

`ifdef COCHLEA_RX_ILLEGAL_CNT_EN
    logic [7:0] ill_cnt;
    logic [1:0] ill_inc;
    logic [8:0] ill_sum;

    assign ill_inc = {1'b0, (read_out_I == 2'b11)} + {1'b0, (read_out_Q == 2'b11)};
    assign ill_sum = {1'b0, ill_cnt} + {7'b0, ill_inc};

    // Saturating count of illegal codes, one per offending lane
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb)        ill_cnt <= '0;
        else if (ovf_clr) ill_cnt <= '0;
        else if (accept)  ill_cnt <= ill_sum[8] ? 8'hFF : ill_sum[7:0];
    end

    assign illegal_cnt = ill_cnt;
`else
    assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_cochlea_readout_rx.sv
// Directed bench for cochlea_readout_rx (WINDOW=64, ACC_W=8, DEPTH=4).
// Inputs change and outputs are checked on the falling clock edge.
module tb_cochlea_readout_rx;

    logic        clk_master = 1'b0;
    logic        rstb       = 1'b0;
    logic        run_en     = 1'b0;
    logic        sample_en  = 1'b0;
    logic [1:0]  read_out_I = 2'b00;
    logic [1:0]  read_out_Q = 2'b00;
    logic        out_valid;
    logic        out_ready  = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  out_seq;
    logic        ovf;
    logic        ovf_clr    = 1'b0;
    logic [7:0]  illegal_cnt;

    int n_cmp = 0;
    int n_err = 0;

    cochlea_readout_rx #(.WINDOW(64), .ACC_W(8), .DEPTH(4)) dut (
        .clk_master (clk_master),
        .rstb       (rstb),
        .run_en     (run_en),
        .sample_en  (sample_en),
        .read_out_I (read_out_I),
        .read_out_Q (read_out_Q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_seq    (out_seq),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk_master = ~clk_master;

    // One strobe, issued at a falling edge, returning at the next one
    task automatic strobe(input logic [1:0] i, input logic [1:0] q);
        sample_en  = 1'b1;
        read_out_I = i;
        read_out_Q = q;
        @(negedge clk_master);
        sample_en  = 1'b0;
        read_out_I = 2'b00;
        read_out_Q = 2'b00;
    endtask

    task automatic strobes(input int n, input logic [1:0] i, input logic [1:0] q);
        for (int k = 0; k < n; k++) strobe(i, q);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk_master);
        out_ready = 1'b0;
    endtask

    task automatic pulse_ovf_clr();
        ovf_clr = 1'b1;
        @(negedge clk_master);
        ovf_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_master);
        rstb = 1'b0;
        @(negedge clk_master);
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        repeat (2) @(negedge clk_master);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset_data got %h want 0000", out_data); end
        n_cmp++; if (out_seq !== 4'd0) begin n_err++; $display("FAIL reset_seq got %0d want 0", out_seq); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_cmp++; if (illegal_cnt !== 8'd0) begin n_err++; $display("FAIL reset_illegal got %0d want 0", illegal_cnt); end
        rstb = 1'b1;
        @(negedge clk_master);
    endtask

    task automatic test_plus_minus();
        run_en = 1'b1;
        strobes(63, 2'b10, 2'b01);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pm_early_valid got %b want 0", out_valid); end
        strobe(2'b10, 2'b01);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pm_valid got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 16'h40C0) begin n_err++; $display("FAIL pm_data got %h want 40c0", out_data); end
        n_cmp++; if (out_seq !== 4'd0) begin n_err++; $display("FAIL pm_seq got %0d want 0", out_seq); end
        pop_one();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pm_popped got %b want 0", out_valid); end
    endtask

    task automatic test_alternate();
        for (int k = 0; k < 64; k++) strobe((k % 2 == 0) ? 2'b10 : 2'b01, 2'b00);
        n_cmp++; if (out_data !== 16'h0000 || out_seq !== 4'd1 || out_valid !== 1'b1)
            begin n_err++; $display("FAIL alt_dense got v=%b d=%h s=%0d want v=1 d=0000 s=1", out_valid, out_data, out_seq); end
        pop_one();
        for (int k = 0; k < 64; k++) begin
            strobe((k % 2 == 0) ? 2'b10 : 2'b01, 2'b00);
            if (k != 63) repeat (2) @(negedge clk_master);
        end
        n_cmp++; if (out_data !== 16'h0000 || out_seq !== 4'd2 || out_valid !== 1'b1)
            begin n_err++; $display("FAIL alt_spaced got v=%b d=%h s=%0d want v=1 d=0000 s=2", out_valid, out_data, out_seq); end
        pop_one();
    endtask

    task automatic test_mixed();
        for (int k = 0; k < 64; k++) strobe((k < 10) ? 2'b10 : 2'b00, (k < 3) ? 2'b01 : 2'b11);
        n_cmp++; if (out_data !== 16'h0AFD || out_seq !== 4'd3)
            begin n_err++; $display("FAIL mixed got d=%h s=%0d want d=0afd s=3", out_data, out_seq); end
`ifdef COCHLEA_RX_ILLEGAL_CNT_EN
        n_cmp++; if (illegal_cnt !== 8'd61) begin n_err++; $display("FAIL mixed_illegal got %0d want 61", illegal_cnt); end
`else
        n_cmp++; if (illegal_cnt !== 8'd0) begin n_err++; $display("FAIL mixed_illegal got %0d want 0", illegal_cnt); end
`endif
        pop_one();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int w = 0; w < 4; w++) strobes(64, 2'b10, 2'b00);
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_four got %b want 0", ovf); end
        strobes(64, 2'b10, 2'b00);
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_five got %b want 1", ovf); end
        repeat (3) @(negedge clk_master);
        n_cmp++; if (out_seq !== 4'd0 || out_data !== 16'h4000)
            begin n_err++; $display("FAIL ovf_hold got d=%h s=%0d want d=4000 s=0", out_data, out_seq); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_seq !== 4'(k))
                begin n_err++; $display("FAIL ovf_drain%0d got v=%b s=%0d want v=1 s=%0d", k, out_valid, out_seq, k); end
            pop_one();
        end
        n_cmp++; if (out_valid !== 1'b0 || ovf !== 1'b1)
            begin n_err++; $display("FAIL ovf_empty got v=%b ovf=%b want v=0 ovf=1", out_valid, ovf); end
        pulse_ovf_clr();
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %b want 0", ovf); end
        strobes(64, 2'b10, 2'b00);
        n_cmp++; if (out_seq !== 4'd5) begin n_err++; $display("FAIL ovf_gap got %0d want 5", out_seq); end
        pop_one();
    endtask

    task automatic test_full_pop();
        for (int w = 0; w < 4; w++) strobes(64, 2'b10, 2'b00);
        strobes(63, 2'b01, 2'b00);
        out_ready = 1'b1;
        strobe(2'b01, 2'b00);
        out_ready = 1'b0;
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf got %b want 0", ovf); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_seq !== 4'(7 + k))
                begin n_err++; $display("FAIL fullpop_drain%0d got v=%b s=%0d want v=1 s=%0d", k, out_valid, out_seq, 7 + k); end
            if (k == 3) begin
                n_cmp++; if (out_data !== 16'hC000) begin n_err++; $display("FAIL fullpop_data got %h want c000", out_data); end
            end
            pop_one();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_empty got %b want 0", out_valid); end
    endtask

    task automatic test_run_en_drop();
        strobes(30, 2'b10, 2'b01);
        run_en = 1'b0;
        @(negedge clk_master);
        strobe(2'b10, 2'b10);
        run_en = 1'b1;
        strobes(34, 2'b00, 2'b10);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL runen_partial got %b want 0", out_valid); end
        strobes(30, 2'b00, 2'b10);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h0040 || out_seq !== 4'd11)
            begin n_err++; $display("FAIL runen_frame got v=%b d=%h s=%0d want v=1 d=0040 s=11", out_valid, out_data, out_seq); end
        pop_one();
    endtask

    task automatic test_async_reset();
        strobes(64, 2'b10, 2'b10);
        strobes(20, 2'b10, 2'b10);
        #2;
        rstb = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_seq !== 4'd0 || out_data !== 16'h0000)
            begin n_err++; $display("FAIL async_rst got v=%b d=%h s=%0d want v=0 d=0000 s=0", out_valid, out_data, out_seq); end
        @(negedge clk_master);
        rstb = 1'b1;
        strobes(63, 2'b10, 2'b10);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_partial got %b want 0", out_valid); end
        strobe(2'b10, 2'b10);
        n_cmp++; if (out_data !== 16'h4040 || out_seq !== 4'd0)
            begin n_err++; $display("FAIL async_frame got d=%h s=%0d want d=4040 s=0", out_data, out_seq); end
        pop_one();
    endtask

    task automatic test_illegal();
        logic [7:0] e10, e64, e264;
`ifdef COCHLEA_RX_ILLEGAL_CNT_EN
        e10 = 8'd20; e64 = 8'd128; e264 = 8'd255;
`else
        e10 = 8'd0;  e64 = 8'd0;   e264 = 8'd0;
`endif
        pulse_ovf_clr();
        strobes(10, 2'b11, 2'b11);
        n_cmp++; if (illegal_cnt !== e10) begin n_err++; $display("FAIL illegal_10 got %0d want %0d", illegal_cnt, e10); end
        strobes(54, 2'b11, 2'b11);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_seq !== 4'd1)
            begin n_err++; $display("FAIL illegal_frame got v=%b d=%h s=%0d want v=1 d=0000 s=1", out_valid, out_data, out_seq); end
        n_cmp++; if (illegal_cnt !== e64) begin n_err++; $display("FAIL illegal_64 got %0d want %0d", illegal_cnt, e64); end
        pop_one();
        strobes(200, 2'b11, 2'b11);
        n_cmp++; if (illegal_cnt !== e264) begin n_err++; $display("FAIL illegal_sat got %0d want %0d", illegal_cnt, e264); end
        pulse_ovf_clr();
        n_cmp++; if (illegal_cnt !== 8'd0) begin n_err++; $display("FAIL illegal_clr got %0d want 0", illegal_cnt); end
    endtask

    initial begin
        test_reset();
        test_plus_minus();
        test_alternate();
        test_mixed();
        test_overflow();
        test_full_pop();
        test_run_en_drop();
        test_async_reset();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
